// File: rtl/uart_ddr_pkg.sv
// Shared types and constants for the UART-to-DDR drain path.
package uart_ddr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0]  WSTRB_FULL     = 4'hF;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte strobe for a word whose low-order cnt lanes hold data
  function automatic logic [3:0] strb_for_count(input logic [2:0] cnt);
    logic [3:0] strb;
    case (cnt)
      3'd0:    strb = 4'h0;
      3'd1:    strb = 4'h1;
      3'd2:    strb = 4'h3;
      3'd3:    strb = 4'h7;
      default: strb = WSTRB_FULL;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/fifo_axil_ddr_writer_axil_single_write.sv
// One AXI4-Lite write at a time: AW/W valids, B acceptance and completion flags.
// Address, data and strobes are driven by the parent straight from its registers.
module axil_single_write
  import uart_ddr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,      // one cycle: raise AW and W valids next cycle
  output logic       awvalid_o,
  input  logic       awready_i,
  output logic       wvalid_o,
  input  logic       wready_i,
  input  logic [1:0] bresp_i,
  input  logic       bvalid_i,
  output logic       bready_o,
  output logic       req_done_o,   // last of AW/W accepted in this cycle
  output logic       resp_done_o,  // B handshake in this cycle
  output logic       resp_err_o    // B handshake with non-OKAY response
);

  logic aw_q, aw_d;
  logic w_q, w_d;
  logic b_q, b_d;
  logic aw_open_s, w_open_s;

  // Handshake bookkeeping: each valid drops after its own handshake
  always_comb begin
    aw_open_s   = aw_q && !awready_i;
    w_open_s    = w_q && !wready_i;
    req_done_o  = (aw_q || w_q) && !aw_open_s && !w_open_s;
    resp_done_o = b_q && bvalid_i;
    resp_err_o  = resp_done_o && (bresp_i != AXI_RESP_OKAY);
    if (start_i) begin
      aw_d = 1'b1;
      w_d  = 1'b1;
    end else begin
      aw_d = aw_open_s;
      w_d  = w_open_s;
    end
    if (req_done_o) begin
      b_d = 1'b1;
    end else if (resp_done_o) begin
      b_d = 1'b0;
    end else begin
      b_d = b_q;
    end
  end

  // Channel state registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q <= 1'b0;
      w_q  <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      aw_q <= aw_d;
      w_q  <= w_d;
      b_q  <= b_d;
    end
  end

  assign awvalid_o = aw_q;
  assign wvalid_o  = w_q;
  assign bready_o  = b_q;

endmodule

// File: rtl/fifo_axil_ddr_writer.sv
// Drains the UART RX FIFO, packs bytes little-endian into 32-bit words and
// writes them to a wrapping DDR window over AXI4-Lite; flush emits partials.
module fifo_axil_ddr_writer
  import uart_ddr_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH     = 8,
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned               REGION_BYTES   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  input  logic                      flush,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [31:0]               words_written,
  output logic [7:0]                err_count,
  output logic                      busy
);

  localparam int unsigned OFF_W = $clog2(REGION_BYTES);

  state_e            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       data_q, data_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       words_q, words_d;
  logic [7:0]        err_q, err_d;
  logic              rd_en_s, start_s;
  logic              req_done_s, resp_done_s, resp_err_s;

  // Next-state: byte intake, word hand-off, address advance and counters
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    offset_d     = offset_q;
    flush_pend_d = flush_pend_q;
    words_d      = words_q;
    err_d        = err_q;
    rd_en_s      = 1'b0;
    start_s      = 1'b0;
    case (state_q)
      IDLE: begin
        // FIFO data always wins over a pending flush
        if (!fifo_empty) begin
          rd_en_s = 1'b1;
          state_d = FETCH;
        end else if (flush_pend_q && (byte_cnt_q != 3'd0)) begin
          start_s = 1'b1;
          state_d = WRITE;
        end else if (flush_pend_q) begin
          flush_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        data_d[{byte_cnt_q[1:0], 3'b000} +: 8] = fifo_dout[7:0];
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'd3) begin
          start_s = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (req_done_s) begin
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      RESP: begin
        if (resp_done_s) begin
          words_d = words_q + 32'd1;
          if (resp_err_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
          // A partial word still occupies a full slot
          offset_d   = offset_q + OFF_W'(BYTES_PER_WORD);
          byte_cnt_d = 3'd0;
          data_d     = 32'h0000_0000;
          if (byte_cnt_q != 3'd4) begin
            flush_pend_d = 1'b0;
          end else begin
            flush_pend_d = flush_pend_q;
          end
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new flush pulse is never lost, even in the cycle a flush is serviced
    flush_pend_d = flush_pend_d | flush;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 3'd0;
      data_q       <= 32'h0000_0000;
      offset_q     <= {OFF_W{1'b0}};
      flush_pend_q <= 1'b0;
      words_q      <= 32'h0000_0000;
      err_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      offset_q     <= offset_d;
      flush_pend_q <= flush_pend_d;
      words_q      <= words_d;
      err_q        <= err_d;
    end
  end

  axil_single_write u_wr (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_s),
    .awvalid_o   (m_awvalid),
    .awready_i   (m_awready),
    .wvalid_o    (m_wvalid),
    .wready_i    (m_wready),
    .bresp_i     (m_bresp),
    .bvalid_i    (m_bvalid),
    .bready_o    (m_bready),
    .req_done_o  (req_done_s),
    .resp_done_o (resp_done_s),
    .resp_err_o  (resp_err_s)
  );

  // Payload comes straight from registers that only change outside WRITE
  assign m_awaddr      = BASE_ADDR + AXI_ADDR_WIDTH'(offset_q);
  assign m_awprot      = 3'b000;
  assign m_wdata       = data_q;
  assign m_wstrb       = strb_for_count(byte_cnt_q);
  assign fifo_rd_en    = rd_en_s;
  assign words_written = words_q;
  assign err_count     = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_axil_ddr_writer.sv
// Randomized scoreboard bench: FIFO/AXI slave models drive the DUT, a word-level
// reference model predicts every write, a monitor checks each handshake.
module tb_fifo_axil_ddr_writer;

  localparam logic [31:0] BASE   = 32'h8000_0100;
  localparam int          REGION = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        flush = 1'b0;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] words_written;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  wr_t        exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pend[$];
  int slot = 0;
  int exp_words = 0;
  int exp_err = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 awready after 3 cycles, 3 never
  int force_err = 0;    // number of upcoming responses forced to SLVERR
  bit rand_err = 1'b0;
  int last_awc = 0;
  int last_wc = 0;

  fifo_axil_ddr_writer #(
    .DATA_WIDTH     (8),
    .AXI_ADDR_WIDTH (32),
    .BASE_ADDR      (BASE),
    .REGION_BYTES   (REGION)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .flush         (flush),
    .m_awaddr      (m_awaddr),
    .m_awprot      (m_awprot),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_wvalid      (m_wvalid),
    .m_wready      (m_wready),
    .m_bresp       (m_bresp),
    .m_bvalid      (m_bvalid),
    .m_bready      (m_bready),
    .words_written (words_written),
    .err_count     (err_count),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: every 4 accepted bytes (or a flush of leftovers) is one slot
  function automatic void emit_word();
    wr_t w;
    w.addr = BASE + 32'((slot * 4) % REGION);
    w.data = 32'h0;
    for (int i = 0; i < pend.size(); i++) w.data = w.data | (32'(pend[i]) << (8 * i));
    w.strb = 4'((1 << pend.size()) - 1);
    exp_q.push_back(w);
    slot++;
    pend.delete();
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    pend.push_back(b);
    if (pend.size() == 4) emit_word();
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    int stable = 0;
    while (stable < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_q.size() == 0 && fifo_empty && !busy) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 4) begin
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    if (pend.size() > 0) emit_word();
    @(negedge clk);
    flush = 1'b0;
  endtask

  // FIFO and AXI slave models: sample at negedge, update just after posedge
  initial begin : responder
    logic aw_hs, w_hs, b_hs, rd;
    int aw_cnt;
    bit aw_got, w_got;
    aw_cnt = 0;
    aw_got = 1'b0;
    w_got = 1'b0;
    forever begin
      @(negedge clk);
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      rd    = fifo_rd_en;
      if (m_awvalid && !aw_got) aw_cnt++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        aw_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
        m_bvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
        continue;
      end
      if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      if (aw_hs) aw_got = 1'b1;
      if (w_hs) w_got = 1'b1;
      if (b_hs) begin
        m_bvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
      end else if (aw_got && w_got && !m_bvalid &&
                   (ready_mode != 1 || $urandom_range(0, 3) != 0)) begin
        m_bvalid = 1'b1;
        if (force_err > 0) begin
          m_bresp = 2'b10;
          force_err--;
        end else if (rand_err) begin
          m_bresp = 2'($urandom_range(0, 3));
        end else begin
          m_bresp = 2'b00;
        end
      end
      case (ready_mode)
        0: begin m_awready = 1'b1; m_wready = 1'b1; end
        1: begin
          m_awready = ($urandom_range(0, 2) != 0);
          m_wready  = ($urandom_range(0, 2) != 0);
        end
        2: begin m_awready = (aw_cnt >= 3); m_wready = 1'b1; end
        default: begin m_awready = 1'b0; m_wready = 1'b0; end
      endcase
    end
  end

  // Monitor: compares each AXI handshake against the scoreboard queue
  initial begin : monitor
    bit aw_seen, w_seen, prev_aw_wait, prev_w_wait;
    int awc, wc;
    logic [31:0] prev_addr, prev_data;
    logic [3:0] prev_strb;
    aw_seen = 1'b0; w_seen = 1'b0; prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
    awc = 0; wc = 0; prev_addr = 32'h0; prev_data = 32'h0; prev_strb = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_seen = 1'b0; w_seen = 1'b0; prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
        awc = 0; wc = 0;
        continue;
      end
      if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
      if (prev_aw_wait) begin
        chk("awvalid_held", 32'(m_awvalid), 32'd1);
        chk("awaddr_stable", m_awaddr, prev_addr);
      end
      if (prev_w_wait) begin
        chk("wvalid_held", 32'(m_wvalid), 32'd1);
        chk("wdata_stable", m_wdata, prev_data);
        chk("wstrb_stable", 32'(m_wstrb), 32'(prev_strb));
      end
      if (m_bready) chk("bready_before_aw_w_done", 32'(aw_seen && w_seen), 32'd1);
      if (m_awvalid) awc++;
      if (m_wvalid) wc++;
      if (m_awvalid && m_awready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_aw: addr %h with no word expected", m_awaddr);
        end else begin
          chk("awaddr", m_awaddr, exp_q[0].addr);
          chk("awprot", 32'(m_awprot), 32'd0);
        end
        aw_seen = 1'b1;
      end
      if (m_wvalid && m_wready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_w: data %h with no word expected", m_wdata);
        end else begin
          chk("wdata", m_wdata, exp_q[0].data);
          chk("wstrb", 32'(m_wstrb), 32'(exp_q[0].strb));
        end
        w_seen = 1'b1;
      end
      if (m_bvalid && m_bready) begin
        exp_words++;
        if (m_bresp != 2'b00 && exp_err < 255) exp_err++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_awc = awc; last_wc = wc;
        awc = 0; wc = 0; aw_seen = 1'b0; w_seen = 1'b0;
      end
      prev_aw_wait = m_awvalid && !m_awready;
      prev_w_wait  = m_wvalid && !m_wready;
      prev_addr = m_awaddr; prev_data = m_wdata; prev_strb = m_wstrb;
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Stimulus sequence
  initial begin : stim
    int n;
    int busy_cycles;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awaddr", m_awaddr, BASE);
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_wvalid), 32'd0);
    chk("rst_bready", 32'(m_bready), 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_words", words_written, 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // One full word, everything ready
    ready_mode = 0;
    push_byte(8'hAA); push_byte(8'h55); push_byte(8'h35); push_byte(8'h09);
    wait_idle("full_word", 200);
    chk("words_after_first", words_written, 32'd1);

    // Partial word via flush, then a full word in the next slot
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_idle("partial_fill", 200);
    do_flush();
    wait_idle("partial_write", 200);
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    wait_idle("after_partial", 200);

    // Flush with nothing buffered: no bus activity at all
    do_flush();
    busy_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    chk("empty_flush_busy_cycles", 32'(busy_cycles), 32'd0);

    // awready delayed three cycles, wready immediate
    ready_mode = 2;
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    wait_idle("aw_delay", 200);
    chk("aw_delay_awvalid_cycles", 32'(last_awc), 32'd4);
    chk("aw_delay_wvalid_cycles", 32'(last_wc), 32'd1);

    // Error response on one write; the next still advances
    ready_mode = 0;
    force_err = 1;
    for (int k = 0; k < 8; k++) push_byte(8'($urandom));
    wait_idle("err_resp", 300);
    chk("err_count_one", 32'(err_count), 32'(exp_err));
    chk("words_after_err", words_written, 32'(exp_words));

    // Randomized bytes, flushes, ready patterns and responses
    ready_mode = 1;
    rand_err = 1'b1;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) push_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle("rand_pre_flush", 1000);
        do_flush();
      end
    end
    wait_idle("rand_end", 3000);
    chk("rand_words", words_written, 32'(exp_words));
    chk("rand_err", 32'(err_count), 32'(exp_err));

    // Error counter saturation
    ready_mode = 0;
    rand_err = 1'b0;
    force_err = 300;
    for (int k = 0; k < 1200; k++) push_byte(8'($urandom));
    wait_idle("saturate", 20000);
    chk("err_saturated_model", 32'(err_count), 32'(exp_err));
    chk("err_saturated_255", 32'(err_count), 32'd255);
    chk("words_after_saturate", words_written, 32'(exp_words));

    // Reset while a write is pending on the bus
    ready_mode = 3;
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    n = 0;
    while (!m_awvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("awvalid_before_reset", 32'(m_awvalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_awvalid", 32'(m_awvalid), 32'd0);
    chk("midrst_wvalid", 32'(m_wvalid), 32'd0);
    chk("midrst_awaddr", m_awaddr, BASE);
    chk("midrst_wdata", m_wdata, 32'd0);
    chk("midrst_words", words_written, 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pend.delete();
    fifo_q.delete();
    slot = 0;
    exp_words = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ready_mode = 0;
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    wait_idle("after_reset", 200);
    chk("words_after_reset", words_written, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
